// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin front end that shares one cache between
// N_REQ requesters. One operation at a time: grant, strobe, wait for done
// (with a watchdog), then pulse the response back to the granted requester.
module cache_req_arbiter #(
  parameter  int WIDTH     = 8,
  parameter  int RAM_DEPTH = 256,
  parameter  int N_REQ     = 4,
  parameter  int TIMEOUT   = 16,
  localparam int AW        = $clog2(RAM_DEPTH),
  localparam int IW        = $clog2(N_REQ),
  localparam int CW        = $clog2(TIMEOUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_we,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   rsp_err,
  output logic                   c_re,
  output logic                   c_we,
  output logic [AW-1:0]          c_addr,
  output logic [WIDTH-1:0]       c_data_in,
  input  logic                   c_done,
  input  logic [WIDTH-1:0]       c_data_out,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  localparam logic [N_REQ-1:0] ONE    = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IW:0]      NREQ_W = (IW+1)'(N_REQ);
  localparam logic [IW-1:0]    LAST   = IW'(N_REQ-1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(TIMEOUT-1);

  state_t            r_state, w_nxt;
  logic [IW-1:0]     r_ptr, r_gnt;
  req_t              r_req, w_req;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_rdata;
  logic              r_err;

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IW-1:0]      w_off, w_gnt, w_ptr_nxt;
  logic [IW:0]        w_sum, w_diff;
  logic               w_any, w_tmo;

  // Rotate the request vector so bit 0 is the requester at ptr; the lowest
  // set bit of the rotated view is the offset of the winner from ptr.
  assign w_dbl = {req_valid, req_valid} >> r_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];
  assign w_any = |req_valid;

  // Priority pick: scanning high to low leaves the lowest set offset.
  always_comb begin
    w_off = '0;
    for (int k = N_REQ-1; k >= 0; k--)
      if (w_rot[k]) w_off = IW'(k);
  end

  // ptr + offset, folded back into 0..N_REQ-1 (also correct for non-pow2 N_REQ).
  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_diff    = w_sum - NREQ_W;
  assign w_gnt     = (w_sum >= NREQ_W) ? w_diff[IW-1:0] : w_sum[IW-1:0];
  assign w_ptr_nxt = (r_gnt == LAST) ? '0 : r_gnt + 1'b1;
  assign w_tmo     = (r_cnt == CNT_MAX);

  // Select the winning requester's fields for latching.
  always_comb begin
    w_req.we    = req_we[w_gnt];
    w_req.addr  = req_addr[w_gnt*AW +: AW];
    w_req.wdata = req_wdata[w_gnt*WIDTH +: WIDTH];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  // Next-state: done beats the watchdog when both land in the same cycle.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_nxt = S_ISSUE;
      S_ISSUE: w_nxt = S_WAIT;
      S_WAIT:  if (c_done || w_tmo) w_nxt = S_RESP;
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Datapath: latch the grant, run the watchdog, capture the response,
  // and advance the rotation pointer past the requester just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_req   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_any) begin
                   r_gnt <= w_gnt;
                   r_req <= w_req;
                 end
        S_ISSUE: r_cnt <= '0;
        S_WAIT:  if (c_done) begin
                   r_rdata <= r_req.we ? '0 : c_data_out;
                   r_err   <= 1'b0;
                 end else if (w_tmo) begin
                   r_rdata <= '0;
                   r_err   <= 1'b1;
                 end else begin
                   r_cnt <= r_cnt + 1'b1;
                 end
        S_RESP:  r_ptr <= w_ptr_nxt;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; req_ready is the only combinational path
  // from the request inputs and is held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    c_re      = 1'b0;
    c_we      = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (w_any && !rst) req_ready = ONE << w_gnt;
      S_ISSUE: begin
                 c_re = ~r_req.we;
                 c_we =  r_req.we;
               end
      S_RESP:  rsp_valid = ONE << r_gnt;
      default: ;
    endcase
  end

  assign c_addr    = r_req.addr;
  assign c_data_in = r_req.wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: random requesters and a random-latency cache
// model; a scoreboard queue carries expected responses to the monitor.
module tb_cache_req_arbiter;
  localparam int W  = 8;
  localparam int RD = 256;
  localparam int N  = 4;
  localparam int T  = 16;
  localparam int AW = $clog2(RD);

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*W-1:0]    req_wdata;
  logic [W-1:0]      rsp_rdata, c_data_in, c_data_out;
  logic              rsp_err, c_re, c_we, c_done, busy;
  logic [AW-1:0]     c_addr;

  cache_req_arbiter #(.WIDTH(W), .RAM_DEPTH(RD), .N_REQ(N), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .c_re(c_re), .c_we(c_we), .c_addr(c_addr), .c_data_in(c_data_in),
    .c_done(c_done), .c_data_out(c_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] vld;
    logic [W-1:0] rdata;
    logic         err;
    int           cyc;
    int           id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Accepted-operation record kept by the monitor, used by the cache model.
  int           acc_id, acc_cyc;
  logic         acc_we;
  logic [AW-1:0] acc_addr;
  logic [W-1:0] acc_wdata;

  // ---------------- cache model ----------------
  logic [W-1:0] mem [RD];
  bit           cm_slow = 0;

  initial begin
    int     cnt, lat, r;
    logic   cm_we;
    logic [W-1:0] cm_rd;
    exp_t   e;
    c_done = 1'b0; c_data_out = '0; cnt = 0; cm_we = 0; cm_rd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cnt = 0; c_done = 1'b0; c_data_out = W'($urandom);
        for (int a = 0; a < RD; a++) mem[a] = W'($urandom);
      end else if (c_re || c_we) begin
        r = $urandom_range(0, 99);
        if (cm_slow || r < 15) lat = 0;          // never answers: watchdog path
        else if (r < 45)       lat = T;          // last legal WAIT cycle
        else if (r < 60)       lat = 1;
        else                   lat = $urandom_range(1, T);
        cm_we = c_we;
        cm_rd = mem[c_addr];
        e.vld   = N'(1) << acc_id;
        e.id    = acc_id;
        e.err   = (lat == 0);
        e.rdata = (lat == 0 || acc_we) ? '0 : mem[acc_addr];
        e.cyc   = acc_cyc + 2 + ((lat == 0) ? T : lat);
        exp_q.push_back(e);
        if (c_we) mem[c_addr] = c_data_in;
        cnt = lat; c_done = 1'b0; c_data_out = W'($urandom);
      end else if (cnt > 0) begin
        cnt--;
        c_done     = (cnt == 0);
        c_data_out = (c_done && !cm_we) ? cm_rd : W'($urandom);
      end else begin
        c_done = 1'b0; c_data_out = W'($urandom);
      end
    end
  end

  // ---------------- monitor / reference model ----------------
  initial begin
    int           m_ptr, n_grants, idx, g;
    bit           m_busy, found;
    logic [N-1:0] exp_rdy;
    logic [1:0]   exp_stb;
    logic [W:0]   m_last;
    exp_t         e;
    m_ptr = 0; n_grants = 0; m_busy = 0; m_last = '0; g = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outs", {req_ready, rsp_valid, c_re, c_we, busy, rsp_err, rsp_rdata, c_addr, c_data_in}, '0);
        m_busy = 0; m_ptr = 0; m_last = '0; exp_q.delete();
      end else begin
        chk("busy", busy, m_busy);
        // Grant: first valid requester at or after ptr, only when idle.
        exp_rdy = '0; found = 0;
        if (!m_busy)
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!found && req_valid[idx]) begin exp_rdy[idx] = 1'b1; g = idx; found = 1; end
          end
        chk("req_ready", req_ready, exp_rdy);
        if (found && n_grants < 5) chk("rr_order", req_ready, N'(1) << (n_grants % 4));
        // Strobe exactly one cycle after accept.
        exp_stb = (m_busy && cyc == acc_cyc + 1) ? {~acc_we, acc_we} : 2'b00;
        chk("strobe", {c_re, c_we}, exp_stb);
        if (exp_stb != 2'b00) begin
          chk("c_addr", c_addr, acc_addr);
          chk("c_data_in", c_data_in, acc_wdata);
        end
        // Response.
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", rsp_valid, '0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, e.vld);
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            m_last = {e.err, e.rdata};
            m_ptr  = (e.id + 1) % N;
            m_busy = 0;
          end
        end else begin
          chk("rsp_hold", {rsp_err, rsp_rdata}, m_last);
          if (m_busy && cyc > acc_cyc + T + 4) begin
            chk("rsp_missing", cyc, acc_cyc + T + 2);
            m_busy = 0; m_ptr = (acc_id + 1) % N; exp_q.delete();
          end
        end
        if (found) begin
          acc_id = g; acc_cyc = cyc; acc_we = req_we[g];
          acc_addr = req_addr[g*AW +: AW]; acc_wdata = req_wdata[g*W +: W];
          m_busy = 1; n_grants++;
        end
      end
    end
  end

  // ---------------- requester driver ----------------
  bit hold_all = 1;
  int p_raise  = 30;

  task automatic new_req(input int i);
    req_valid[i] = 1'b1;
    req_we[i]    = 1'($urandom_range(0, 1));
    req_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    req_wdata[i*W +: W]  = W'($urandom);
  endtask

  task automatic step();
    logic [N-1:0] rdy;
    @(negedge clk); rdy = req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (rdy[i]) begin
        if (hold_all || $urandom_range(0, 1) == 1) new_req(i);
        else req_valid[i] = 1'b0;
      end else if (!req_valid[i] && $urandom_range(0, 99) < p_raise) new_req(i);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) new_req(i);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // All requesters held valid from reset: strict rotation.
    repeat (150) step();
    hold_all = 0;
    repeat (3000) step();
    // Reset in the middle of a WAIT.
    cm_slow = 1; p_raise = 100;
    k = 0;
    while (!busy && k < 60) begin step(); k++; end
    chk("mid_rst_busy_before", busy, 1'b1);
    repeat (4) step();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_outs", {c_re, c_we, rsp_valid, req_ready}, '0);
    for (int i = 0; i < N; i++) new_req(i);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; cm_slow = 0; p_raise = 30;
    repeat (500) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_req_arbiter.md
# cache_req_arbiter

Round-robin arbiter and sequencer that shares one `cache_top` instance between `N_REQ` independent requesters. It accepts one request at a time and issues it to the cache as a single-cycle `re`/`we` pulse. It then waits for the cache `done`, with a timeout watchdog, and returns the read data or an error to the granted requester. It sits between the requester ports and the cache's microprocessor-side ports.

## Interface
- `WIDTH`, 8, data width; matches cache `WIDTH`
- `RAM_DEPTH`, 256, address space; `AW = $clog2(RAM_DEPTH)`
- `N_REQ`, 4, number of requesters (≥2); `IW = $clog2(N_REQ)`
- `TIMEOUT`, 16, maximum WAIT cycles before error (≥2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `req_valid`  in  N_REQ  per-requester request
- `req_we`  in  N_REQ  1 = write, 0 = read
- `req_addr`  in  N_REQ*AW  flattened; requester i at `[i*AW +: AW]`
- `req_wdata`  in  N_REQ*WIDTH  flattened; requester i at `[i*WIDTH +: WIDTH]`
- `req_ready`  out  N_REQ  one-hot accept pulse
- `rsp_valid`  out  N_REQ  one-hot completion pulse
- `rsp_rdata`  out  WIDTH  shared read data; valid with `rsp_valid`
- `rsp_err`  out  1  timeout flag; valid with `rsp_valid`
- `c_re`, `c_we`  out  1 each  cache operation strobes
- `c_addr`  out  AW  cache address
- `c_data_in`  out  WIDTH  cache write data
- `c_done`  in  1  cache completion
- `c_data_out`  in  WIDTH  cache read data
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE; rotation pointer `ptr` resets to 0.
- **IDLE:**
  - If any `req_valid` is set, grant the first set bit searching `ptr, ptr+1, … mod N_REQ`.
  - `req_ready[g]` is combinationally high in this cycle.
  - Latch `g`, `req_we[g]`, `req_addr[g]` and `req_wdata[g]`, then go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE:**
  - Drive exactly one cycle of `c_re = ~we_l` or `c_we = we_l`, with `c_addr`/`c_data_in` taken from the latches.
  - Clear the watchdog counter and go to WAIT.
  - `c_done` is ignored in this state.
- **WAIT:**
  - `c_re`/`c_we` are held at 0. `c_addr`/`c_data_in` keep their latched values and are never changed mid-operation.
  - If `c_done` = 1: capture `c_data_out` (reads) or 0 (writes) into `rsp_rdata`, set `rsp_err` = 0, go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`-1 without `c_done`, set `rsp_rdata` = 0 and `rsp_err` = 1, then go to RESP. This gives exactly `TIMEOUT` WAIT cycles.
  - If `c_done` is high in the same cycle the counter reaches `TIMEOUT`-1, `c_done` wins (no error).
- **RESP:**
  - `rsp_valid[g]` = 1 for one cycle.
  - Set `ptr = (g+1) mod N_REQ`, with wrap-around from `N_REQ`-1 to 0, then go to IDLE.
- **Requester rules:**
  - Hold `req_valid` and all request fields stable until `req_ready`.
  - After acceptance, `req_valid` may stay high to request the next operation. That request is re-arbitrated at the next IDLE with the updated `ptr`, so no requester can starve.
- `req_ready`, `rsp_valid` and `c_re`/`c_we` are never high for more than one cycle per operation, and each is one-hot or zero.
- **Reset mid-operation:** return immediately to IDLE. All outputs go to 0 and `ptr` = 0. No `rsp_valid` is issued for the abandoned operation.

## Timing
- **Reset values:**
  - `req_ready`, `rsp_valid`, `c_re`, `c_we`, `busy`, `rsp_err` = 0.
  - `rsp_rdata`, `c_addr`, `c_data_in` = 0.
- `req_ready` is combinational from `req_valid`/`ptr` in IDLE. All other outputs are registered or decoded from state.
- **Minimum latency:** request accepted in cycle 0 (IDLE), strobe in cycle 1 (ISSUE), `c_done` sampled from cycle 2, `rsp_valid` in cycle 3.
- Minimum spacing between accepts is 4 cycles.
- **Timeout path:** `rsp_valid` arrives `TIMEOUT`+2 cycles after accept.
- `rsp_rdata`/`rsp_err` hold their last value after RESP until the next completion.

## Test plan
- **Single read:** requester 2 reads addr 0x35; cache returns `c_done` with 0xA7 two WAIT cycles later → `req_ready[2]` in cycle 0, `c_re` pulse in cycle 1 with `c_addr` = 0x35, `rsp_valid[2]` with `rsp_rdata` = 0xA7 and `rsp_err` = 0 in cycle 4.
- **Single write:** requester 0 writes 0x5C to 0x10 → one `c_we` pulse with `c_data_in` = 0x5C, `c_re` stays 0, `rsp_valid[0]` with `rsp_rdata` = 0.
- **Round-robin:** all 4 requesters held valid from reset → grant order 0, 1, 2, 3, 0; each `req_ready` is one-hot.
- **Rotation skip:** after a grant to 2, only requesters 1 and 3 are valid → 3 is granted, then 1.
- **Timeout:** `c_done` held low → `rsp_valid` with `rsp_err` = 1 and `rsp_rdata` = 0 exactly 18 cycles after accept (`TIMEOUT` = 16). A `c_done` arriving on the 16th WAIT cycle → no error.
- **Reset mid-operation:** assert `rst` during WAIT → `busy` and all strobes drop to 0 immediately, no `rsp_valid`, and the next grant starts from requester 0.
